// File: rtl/picobello_dummy_err_slv.sv
// picobello_dummy_err_slv
//
// Error endpoint for dummy (non-existent) mesh tiles. It sits behind the NoC
// router port and answers every stray AXI-style transaction with an error
// response, so a requester that wanders into an empty tile never hangs.
//
// Ports
//    clk_i, rst_i                        clock, async active-high reset
//    aw_valid_i/aw_ready_o, aw_id_i      write address (aw_len is not needed)
//    w_valid_i/w_ready_o, w_last_i       write data (payload is discarded)
//    b_valid_o/b_ready_i, b_id_o, b_resp_o
//    ar_valid_i/ar_ready_o, ar_id_i, ar_len_i
//    r_valid_o/r_ready_i, r_id_o, r_data_o, r_resp_o, r_last_o
//    err_cnt_o                           saturating count of terminated transactions
//
// Build option: define PICOBELLO_DUMMY_ERR_CNT_EN to implement err_cnt_o.
// Without it err_cnt_o is tied to zero and the counter is not built.
//
// Write FSM
//    state  | meaning
//    W_IDLE | aw_ready_o high, waiting for a write address
//    W_DATA | w_ready_o high, draining beats until w_last_i
//    W_RESP | b_valid_o high with the captured ID
// Read FSM
//    state  | meaning
//    R_IDLE | ar_ready_o high, waiting for a read address
//    R_DATA | r_valid_o high, one zero beat per handshake, len+1 beats

module picobello_dummy_err_slv #(
   parameter int unsigned IdWidth   = 4,
   parameter int unsigned DataWidth = 64,
   parameter logic [1:0]  ErrResp   = 2'b11
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 aw_valid_i,
   output logic                 aw_ready_o,
   input  logic [IdWidth-1:0]   aw_id_i,
   input  logic                 w_valid_i,
   output logic                 w_ready_o,
   input  logic                 w_last_i,
   output logic                 b_valid_o,
   input  logic                 b_ready_i,
   output logic [IdWidth-1:0]   b_id_o,
   output logic [1:0]           b_resp_o,
   input  logic                 ar_valid_i,
   output logic                 ar_ready_o,
   input  logic [IdWidth-1:0]   ar_id_i,
   input  logic [7:0]           ar_len_i,
   output logic                 r_valid_o,
   input  logic                 r_ready_i,
   output logic [IdWidth-1:0]   r_id_o,
   output logic [DataWidth-1:0] r_data_o,
   output logic [1:0]           r_resp_o,
   output logic                 r_last_o,
   output logic [15:0]          err_cnt_o
);

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
   typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

   w_state_e           w_state_q, w_state_d;
   r_state_e           r_state_q, r_state_d;
   logic [IdWidth-1:0] w_id_q;
   logic [IdWidth-1:0] r_id_q;
   logic [7:0]         r_len_q;
   logic [7:0]         r_cnt_q;
   logic               rdy_en_q;

   logic aw_hs, w_hs, b_hs, ar_hs, r_hs, r_done_hs;

   // Address readies stay low during reset and rise on the first edge after
   // release, so nothing is accepted while the block is still coming up.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) rdy_en_q <= 1'b0;
      else       rdy_en_q <= 1'b1;
   end

   assign aw_hs     = aw_valid_i & aw_ready_o;
   assign w_hs      = w_valid_i & w_ready_o;
   assign b_hs      = b_valid_o & b_ready_i;
   assign ar_hs     = ar_valid_i & ar_ready_o;
   assign r_hs      = r_valid_o & r_ready_i;
   assign r_done_hs = r_hs & r_last_o;

   // ---------------- write path ----------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         w_state_q <= W_IDLE;
         w_id_q    <= '0;
      end else begin
         w_state_q <= w_state_d;
         if (aw_hs) w_id_q <= aw_id_i;
      end
   end

   always_comb begin
      w_state_d  = w_state_q;
      aw_ready_o = 1'b0;
      w_ready_o  = 1'b0;
      b_valid_o  = 1'b0;
      case (w_state_q)
         W_IDLE: begin
            aw_ready_o = rdy_en_q;
            if (aw_hs) w_state_d = W_DATA;
         end
         W_DATA: begin
            w_ready_o = 1'b1;
            if (w_hs && w_last_i) w_state_d = W_RESP;
         end
         W_RESP: begin
            b_valid_o = 1'b1;
            if (b_ready_i) w_state_d = W_IDLE;
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   assign b_id_o   = w_id_q;
   assign b_resp_o = ErrResp;

   // ---------------- read path ----------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state_q <= R_IDLE;
         r_id_q    <= '0;
         r_len_q   <= '0;
         r_cnt_q   <= '0;
      end else begin
         r_state_q <= r_state_d;
         if (ar_hs) begin
            r_id_q  <= ar_id_i;
            r_len_q <= ar_len_i;
            r_cnt_q <= '0;
         end else if (r_hs) begin
            // Wraps 255->0 only on the final beat of a 256-beat burst,
            // when the FSM is leaving R_DATA anyway.
            r_cnt_q <= r_cnt_q + 8'd1;
         end
      end
   end

   always_comb begin
      r_state_d  = r_state_q;
      ar_ready_o = 1'b0;
      r_valid_o  = 1'b0;
      case (r_state_q)
         R_IDLE: begin
            ar_ready_o = rdy_en_q;
            if (ar_hs) r_state_d = R_DATA;
         end
         R_DATA: begin
            r_valid_o = 1'b1;
            if (r_ready_i && r_last_o) r_state_d = R_IDLE;
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   assign r_id_o   = r_id_q;
   assign r_data_o = '0;
   assign r_resp_o = ErrResp;
   assign r_last_o = (r_state_q == R_DATA) && (r_cnt_q == r_len_q);

   // ---------------- error counter ----------------
`ifdef PICOBELLO_DUMMY_ERR_CNT_EN
   logic [15:0] err_cnt_q;
   logic [1:0]  err_inc;
   logic [16:0] err_sum;

   assign err_inc = {1'b0, b_hs} + {1'b0, r_done_hs};
   assign err_sum = {1'b0, err_cnt_q} + {15'd0, err_inc};

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)           err_cnt_q <= '0;
      else if (err_sum[16]) err_cnt_q <= 16'hFFFF;
      else                 err_cnt_q <= err_sum[15:0];
   end

   assign err_cnt_o = err_cnt_q;
`else
   assign err_cnt_o = '0;
`endif

endmodule
